// File: rtl/german_system_param.sv
// German cache-coherence system: NODE_NUM caches, three channels per node and a home directory.
// One externally selected guarded rule fires per cycle; CtrlProp/DataProp are checked continuously.
module german_system_param #(
  parameter int unsigned       NODE_NUM  = 3,
  parameter int unsigned       DATA_W    = 2,
  parameter int unsigned       NODE_W    = (NODE_NUM > 2) ? $clog2(NODE_NUM) : 1,
  parameter logic [DATA_W-1:0] INIT_DATA = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_en,
  input  logic [3:0]        io_rule,
  input  logic [NODE_W-1:0] io_node,
  input  logic [DATA_W-1:0] io_data,
  output logic              io_fired,
  output logic              io_ctrl_ok,
  output logic              io_data_ok,
  output logic              io_violation,
  output logic [CNT_W-1:0]  io_fire_count
);

  localparam logic [2:0] CMD_EMPTY  = 3'd0;
  localparam logic [2:0] CMD_REQS   = 3'd1;
  localparam logic [2:0] CMD_REQE   = 3'd2;
  localparam logic [2:0] CMD_INV    = 3'd3;
  localparam logic [2:0] CMD_INVACK = 3'd4;
  localparam logic [2:0] CMD_GNTS   = 3'd5;
  localparam logic [2:0] CMD_GNTE   = 3'd6;
  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;

  logic [NODE_NUM-1:0][1:0]        cache_state, cache_state_n;
  logic [NODE_NUM-1:0][DATA_W-1:0] cache_data, cache_data_n;
  logic [NODE_NUM-1:0][2:0]        chan1_cmd, chan1_cmd_n;
  logic [NODE_NUM-1:0][2:0]        chan2_cmd, chan2_cmd_n;
  logic [NODE_NUM-1:0][2:0]        chan3_cmd, chan3_cmd_n;
  logic [NODE_NUM-1:0][DATA_W-1:0] chan2_data, chan2_data_n;
  logic [NODE_NUM-1:0][DATA_W-1:0] chan3_data, chan3_data_n;
  logic [NODE_NUM-1:0]             shr_set, shr_set_n;
  logic [NODE_NUM-1:0]             inv_set, inv_set_n;
  logic                            ex_gntd, ex_gntd_n;
  logic [2:0]                      cur_cmd, cur_cmd_n;
  logic [NODE_W-1:0]               cur_ptr, cur_ptr_n;
  logic [DATA_W-1:0]               mem_data, mem_data_n;
  logic [DATA_W-1:0]               aux_data, aux_data_n;
  logic                            fire_c;
  logic                            node_ok_c;
  logic [NODE_W-1:0]               idx_c;

  assign node_ok_c = 32'(io_node) < NODE_NUM;
  assign idx_c     = node_ok_c ? io_node : '0;

  // Guarded rule evaluation and next-state computation
  always_comb begin
    cache_state_n = cache_state;
    cache_data_n  = cache_data;
    chan1_cmd_n   = chan1_cmd;
    chan2_cmd_n   = chan2_cmd;
    chan3_cmd_n   = chan3_cmd;
    chan2_data_n  = chan2_data;
    chan3_data_n  = chan3_data;
    shr_set_n     = shr_set;
    inv_set_n     = inv_set;
    ex_gntd_n     = ex_gntd;
    cur_cmd_n     = cur_cmd;
    cur_ptr_n     = cur_ptr;
    mem_data_n    = mem_data;
    aux_data_n    = aux_data;
    fire_c        = 1'b0;
    if (io_en && node_ok_c) begin
      unique case (io_rule)
        4'd0: if (chan1_cmd[idx_c] == CMD_EMPTY && cache_state[idx_c] == ST_I) begin
          fire_c = 1'b1;
          chan1_cmd_n[idx_c] = CMD_REQS;
        end
        4'd1: if (chan1_cmd[idx_c] == CMD_EMPTY &&
                  (cache_state[idx_c] == ST_I || cache_state[idx_c] == ST_S)) begin
          fire_c = 1'b1;
          chan1_cmd_n[idx_c] = CMD_REQE;
        end
        4'd2, 4'd3: if (cur_cmd == CMD_EMPTY &&
                        chan1_cmd[idx_c] == ((io_rule == 4'd2) ? CMD_REQS : CMD_REQE)) begin
          fire_c = 1'b1;
          cur_cmd_n = chan1_cmd[idx_c];
          cur_ptr_n = idx_c;
          chan1_cmd_n[idx_c] = CMD_EMPTY;
          inv_set_n = shr_set;
        end
        4'd4: if (chan2_cmd[idx_c] == CMD_EMPTY && inv_set[idx_c] &&
                  (cur_cmd == CMD_REQE || (cur_cmd == CMD_REQS && ex_gntd))) begin
          fire_c = 1'b1;
          chan2_cmd_n[idx_c] = CMD_INV;
          inv_set_n[idx_c] = 1'b0;
        end
        4'd5: if (chan2_cmd[idx_c] == CMD_INV && chan3_cmd[idx_c] == CMD_EMPTY) begin
          fire_c = 1'b1;
          chan2_cmd_n[idx_c]  = CMD_EMPTY;
          chan2_data_n[idx_c] = '0;
          chan3_cmd_n[idx_c]  = CMD_INVACK;
          if (cache_state[idx_c] == ST_E) chan3_data_n[idx_c] = cache_data[idx_c];
          cache_state_n[idx_c] = ST_I;
          cache_data_n[idx_c]  = '0;
        end
        4'd6: if (chan3_cmd[idx_c] == CMD_INVACK && cur_cmd != CMD_EMPTY) begin
          fire_c = 1'b1;
          chan3_cmd_n[idx_c]  = CMD_EMPTY;
          chan3_data_n[idx_c] = '0;
          shr_set_n[idx_c]    = 1'b0;
          if (ex_gntd) begin
            ex_gntd_n  = 1'b0;
            mem_data_n = chan3_data[idx_c];
          end
        end
        4'd7, 4'd8: if (cur_ptr == idx_c && chan2_cmd[idx_c] == CMD_EMPTY && !ex_gntd &&
                        ((io_rule == 4'd7 && cur_cmd == CMD_REQS) ||
                         (io_rule == 4'd8 && cur_cmd == CMD_REQE && shr_set == '0))) begin
          fire_c = 1'b1;
          chan2_cmd_n[idx_c]  = (io_rule == 4'd7) ? CMD_GNTS : CMD_GNTE;
          chan2_data_n[idx_c] = mem_data;
          shr_set_n[idx_c]    = 1'b1;
          cur_cmd_n           = CMD_EMPTY;
          if (io_rule == 4'd8) ex_gntd_n = 1'b1;
        end
        4'd9, 4'd10: if (chan2_cmd[idx_c] == ((io_rule == 4'd9) ? CMD_GNTS : CMD_GNTE)) begin
          fire_c = 1'b1;
          cache_state_n[idx_c] = (io_rule == 4'd9) ? ST_S : ST_E;
          cache_data_n[idx_c]  = chan2_data[idx_c];
          chan2_cmd_n[idx_c]   = CMD_EMPTY;
          chan2_data_n[idx_c]  = '0;
        end
        4'd11: if (cache_state[idx_c] == ST_E) begin
          fire_c = 1'b1;
          cache_data_n[idx_c] = io_data;
          aux_data_n          = io_data;
        end
        default: fire_c = 1'b0;
      endcase
    end
  end

  // Coherence invariants over the current state; state 3 counts as not I
  always_comb begin
    io_ctrl_ok = 1'b1;
    io_data_ok = !(!ex_gntd && mem_data != aux_data);
    for (int unsigned i = 0; i < NODE_NUM; i++) begin
      if (cache_state[i] != ST_I && cache_data[i] != aux_data) io_data_ok = 1'b0;
      for (int unsigned j = 0; j < NODE_NUM; j++) begin
        if (i != j) begin
          if (cache_state[i] == ST_E && cache_state[j] != ST_I) io_ctrl_ok = 1'b0;
          if (cache_state[i] == ST_S && cache_state[j] != ST_I && cache_state[j] != ST_S)
            io_ctrl_ok = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cache_state   <= '0;
      cache_data    <= '0;
      chan1_cmd     <= '0;
      chan2_cmd     <= '0;
      chan3_cmd     <= '0;
      chan2_data    <= '0;
      chan3_data    <= '0;
      shr_set       <= '0;
      inv_set       <= '0;
      ex_gntd       <= 1'b0;
      cur_cmd       <= CMD_EMPTY;
      cur_ptr       <= '0;
      mem_data      <= INIT_DATA;
      aux_data      <= INIT_DATA;
      io_fired      <= 1'b0;
      io_fire_count <= '0;
      io_violation  <= 1'b0;
    end else begin
      cache_state <= cache_state_n;
      cache_data  <= cache_data_n;
      chan1_cmd   <= chan1_cmd_n;
      chan2_cmd   <= chan2_cmd_n;
      chan3_cmd   <= chan3_cmd_n;
      chan2_data  <= chan2_data_n;
      chan3_data  <= chan3_data_n;
      shr_set     <= shr_set_n;
      inv_set     <= inv_set_n;
      ex_gntd     <= ex_gntd_n;
      cur_cmd     <= cur_cmd_n;
      cur_ptr     <= cur_ptr_n;
      mem_data    <= mem_data_n;
      aux_data    <= aux_data_n;
      io_fired    <= fire_c;
      if (fire_c && io_fire_count != {CNT_W{1'b1}}) io_fire_count <= io_fire_count + CNT_W'(1);
      if (!(io_ctrl_ok && io_data_ok)) io_violation <= 1'b1;
    end
  end

endmodule
